// File: rtl/calc_seq_ctrl_pkg.sv
// Shared key codes, state encoding and operand payload for the calculator sequencer.
// The display block decodes `state` with the same state_t encoding.
package calc_seq_ctrl_pkg;

    localparam int unsigned W_KEY   = 8;
    localparam int unsigned W_STATE = 3;
    localparam int unsigned W_CNT   = 2;
    localparam int unsigned W_VAL   = 8;

    localparam logic [W_KEY-1:0] encout_ADD  = 8'd10;
    localparam logic [W_KEY-1:0] encout_SUB  = 8'd11;
    localparam logic [W_KEY-1:0] encout_Mult = 8'd12;
    localparam logic [W_KEY-1:0] encout_Div  = 8'd13;
    localparam logic [W_KEY-1:0] encout_EQ   = 8'd14;
    localparam logic [W_KEY-1:0] encout_CLR  = 8'd15;

    typedef enum logic [W_STATE-1:0] {
        ST_ENT_A = 3'd0,
        ST_ENT_B = 3'd1,
        ST_CALC  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    typedef struct packed {
        logic [W_KEY-1:0] tens;
        logic [W_KEY-1:0] units;
    } operand_t;

    function automatic logic is_digit(input logic [W_KEY-1:0] code);
        return code <= 8'd9;
    endfunction

    function automatic logic is_op(input logic [W_KEY-1:0] code);
        return (code == encout_ADD) || (code == encout_SUB) ||
               (code == encout_Mult) || (code == encout_Div);
    endfunction

    // Two-digit operand value, 0..99.
    function automatic logic [W_VAL-1:0] operand_value(input operand_t op);
        return W_VAL'(op.tens * 8'd10) + W_VAL'(op.units);
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_digit_shift.sv
// Two-digit decimal entry register for one operand: shift-in, clear and load-first-digit.
module calc_digit_shift
    import calc_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load_first,
    input  logic             i_shift,
    input  logic [W_KEY-1:0] i_digit,
    output operand_t         o_val,
    output logic [W_CNT-1:0] o_cnt
);

    operand_t         r_val;
    logic [W_CNT-1:0] r_cnt;

    // Third and later digits are dropped once two are held.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_val <= '0;
            r_cnt <= '0;
        end else if (i_load_first) begin
            r_val.tens  <= '0;
            r_val.units <= i_digit;
            r_cnt       <= W_CNT'(1);
        end else if (i_shift) begin
            case (r_cnt)
                2'd0: begin
                    r_val.tens  <= '0;
                    r_val.units <= i_digit;
                    r_cnt       <= W_CNT'(1);
                end
                2'd1: begin
                    r_val.tens  <= r_val.units;
                    r_val.units <= i_digit;
                    r_cnt       <= W_CNT'(2);
                end
                default: begin
                    r_val <= r_val;
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign o_val = r_val;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad-to-arithmetic sequencer: assembles two 2-digit operands and an operator,
// fires the combinational calculation block for one cycle and holds its result.
module calc_seq_ctrl
    import calc_seq_ctrl_pkg::*;
#(
    parameter int unsigned W_OUT = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [W_KEY-1:0]   key_code,
    output logic [W_KEY-1:0]   A1,
    output logic [W_KEY-1:0]   A0,
    output logic [W_KEY-1:0]   B1,
    output logic [W_KEY-1:0]   B0,
    output logic [W_KEY-1:0]   OP,
    output logic               calc_rst,
    input  logic [W_OUT-1:0]   calc_out,
    output logic [W_OUT-1:0]   result,
    output logic               neg,
    output logic               err,
    output logic               result_valid,
    output logic [W_STATE-1:0] state
);

    state_t             r_state;
    logic [W_KEY-1:0]   r_op;
    logic               r_calc_rst;
    logic [W_OUT-1:0]   r_result;
    logic               r_neg;
    logic               r_err;
    logic               r_result_valid;

    operand_t           w_a;
    operand_t           w_b;
    logic [W_CNT-1:0]   w_a_cnt;
    logic [W_CNT-1:0]   w_b_cnt;
    logic               w_clr;
    logic               w_digit;
    logic               w_op_key;
    logic               w_eq;
    logic               w_show_digit;
    logic [W_VAL-1:0]   w_a_val;
    logic [W_VAL-1:0]   w_b_val;

    assign w_clr        = key_valid && (key_code == encout_CLR);
    assign w_digit      = key_valid && is_digit(key_code);
    assign w_op_key     = key_valid && is_op(key_code);
    assign w_eq         = key_valid && (key_code == encout_EQ);
    assign w_show_digit = w_digit && (r_state == ST_SHOW);
    assign w_a_val      = operand_value(w_a);
    assign w_b_val      = operand_value(w_b);

    calc_digit_shift u_digits_a (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clr),
        .i_load_first (w_show_digit),
        .i_shift      (w_digit && (r_state == ST_ENT_A)),
        .i_digit      (key_code),
        .o_val        (w_a),
        .o_cnt        (w_a_cnt)
    );

    // A digit in SHOW starts a fresh calculation, so B is cleared alongside.
    calc_digit_shift u_digits_b (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clr || w_show_digit),
        .i_load_first (1'b0),
        .i_shift      (w_digit && (r_state == ST_ENT_B)),
        .i_digit      (key_code),
        .o_val        (w_b),
        .o_cnt        (w_b_cnt)
    );

    // Sequencer FSM; calc_rst is registered so it drops together with entry to CALC.
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_state        <= ST_ENT_A;
            r_op           <= '0;
            r_calc_rst     <= 1'b1;
            r_result       <= '0;
            r_neg          <= 1'b0;
            r_err          <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ENT_A: begin
                    if (w_op_key && (w_a_cnt != '0)) begin
                        r_op    <= key_code;
                        r_state <= ST_ENT_B;
                    end
                end
                ST_ENT_B: begin
                    if (w_op_key && (w_b_cnt == '0)) begin
                        r_op <= key_code;
                    end else if (w_eq && (w_b_cnt != '0)) begin
                        r_state    <= ST_CALC;
                        r_calc_rst <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if ((r_op == encout_Div) && (w_b_val == '0)) begin
                        r_state    <= ST_ERR;
                        r_err      <= 1'b1;
                        r_calc_rst <= 1'b1;
                    end else begin
                        if ((r_op == encout_SUB) && (w_a_val < w_b_val)) begin
                            r_result <= (~calc_out) + W_OUT'(1);
                            r_neg    <= 1'b1;
                        end else begin
                            r_result <= calc_out;
                            r_neg    <= 1'b0;
                        end
                        r_result_valid <= 1'b1;
                        r_state        <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (w_digit) begin
                        r_state        <= ST_ENT_A;
                        r_op           <= '0;
                        r_neg          <= 1'b0;
                        r_err          <= 1'b0;
                        r_result_valid <= 1'b0;
                        r_calc_rst     <= 1'b1;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state    <= ST_ENT_A;
                    r_calc_rst <= 1'b1;
                end
            endcase
        end
    end

    assign A1           = w_a.tens;
    assign A0           = w_a.units;
    assign B1           = w_b.tens;
    assign B0           = w_b.units;
    assign OP           = r_op;
    assign calc_rst     = r_calc_rst;
    assign result       = r_result;
    assign neg          = r_neg;
    assign err          = r_err;
    assign result_valid = r_result_valid;
    assign state        = W_STATE'(r_state);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl with a behavioural model of the calculation block.
module tb_calc_seq_ctrl;
    import calc_seq_ctrl_pkg::*;

    localparam int unsigned W_OUT = 14;

    typedef struct {
        logic [W_OUT-1:0] result;
        logic             neg;
        logic             err;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               key_valid;
    logic [W_KEY-1:0]   key_code;
    logic [W_KEY-1:0]   A1, A0, B1, B0, OP;
    logic               calc_rst;
    logic [W_OUT-1:0]   calc_out;
    logic [W_OUT-1:0]   result;
    logic               neg, err, result_valid;
    logic [W_STATE-1:0] state;

    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];
    int   m_a, m_b;

    localparam logic [68:0] RESET_VEC = {40'd0, 14'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};

    calc_seq_ctrl #(.W_OUT(W_OUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .A1           (A1),
        .A0           (A0),
        .B1           (B1),
        .B0           (B0),
        .OP           (OP),
        .calc_rst     (calc_rst),
        .calc_out     (calc_out),
        .result       (result),
        .neg          (neg),
        .err          (err),
        .result_valid (result_valid),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational calculation block.
    always_comb begin
        m_a      = int'(A1) * 10 + int'(A0);
        m_b      = int'(B1) * 10 + int'(B0);
        calc_out = '0;
        if (!calc_rst) begin
            case (OP)
                encout_ADD:  calc_out = W_OUT'(m_a + m_b);
                encout_SUB:  calc_out = W_OUT'(m_a - m_b);
                encout_Mult: calc_out = W_OUT'(m_a * m_b);
                encout_Div:  calc_out = (m_b != 0) ? W_OUT'(m_a / m_b) : '0;
                default:     calc_out = '0;
            endcase
        end
    end

    task automatic press(input logic [W_KEY-1:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic enter_num(input int v);
        if (v >= 10) press(W_KEY'(v / 10));
        press(W_KEY'(v % 10));
    endtask

    // Push the expected outcome, press EQ, then pop and compare when the DUT responds.
    task automatic do_eq(input int a, input int b, input logic [W_KEY-1:0] op, input string name);
        exp_t e;
        exp_t got;
        int   edges;
        e.result = '0;
        e.neg    = 1'b0;
        e.err    = 1'b0;
        if (op == encout_Div && b == 0) e.err = 1'b1;
        else if (op == encout_ADD) e.result = W_OUT'(a + b);
        else if (op == encout_Mult) e.result = W_OUT'(a * b);
        else if (op == encout_Div) e.result = W_OUT'(a / b);
        else if (a < b) begin
            e.result = W_OUT'(b - a);
            e.neg    = 1'b1;
        end else e.result = W_OUT'(a - b);
        sb_q.push_back(e);

        @(negedge clk);
        key_valid = 1'b1;
        key_code  = encout_EQ;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = '0;
        edges = 1;
        while (!(result_valid || err) && edges < 6) begin
            @(posedge clk);
            #1;
            edges++;
        end
        got = sb_q.pop_front();
        n_checks++;
        if (!(result_valid || err)) begin
            n_errors++;
            $display("FAIL %s timeout: no result after %0d edges, required 2", name, edges);
            return;
        end
        n_checks++;
        if (edges !== 2) begin
            n_errors++;
            $display("FAIL %s latency: got %0d edges, required 2", name, edges);
        end
        n_checks++;
        if (err !== got.err) begin
            n_errors++;
            $display("FAIL %s err: got %0b, required %0b", name, err, got.err);
        end
        if (got.err) begin
            n_checks++;
            if ({result_valid, state} !== {1'b0, ST_ERR}) begin
                n_errors++;
                $display("FAIL %s err_state: got rv=%0b state=%0d, required rv=0 state=%0d",
                         name, result_valid, state, ST_ERR);
            end
        end else begin
            n_checks++;
            if ({result, neg, result_valid, state} !== {got.result, got.neg, 1'b1, ST_SHOW}) begin
                n_errors++;
                $display("FAIL %s result: got %0d neg=%0b rv=%0b state=%0d, required %0d neg=%0b rv=1 state=%0d",
                         name, result, neg, result_valid, state, got.result, got.neg, ST_SHOW);
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({A1, A0, B1, B0, OP} !== 40'd0) begin
            n_errors++;
            $display("FAIL reset_operands: got %h, required 0", {A1, A0, B1, B0, OP});
        end
        n_checks++;
        if ({result, neg, err, result_valid} !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_result: got result=%0d neg=%0b err=%0b rv=%0b, required all 0",
                     result, neg, err, result_valid);
        end
        n_checks++;
        if ({calc_rst, state} !== {1'b1, ST_ENT_A}) begin
            n_errors++;
            $display("FAIL reset_ctrl: got calc_rst=%0b state=%0d, required 1/0", calc_rst, state);
        end
    endtask

    task automatic test_add();
        press(encout_CLR);
        press(8'd4); press(8'd2); press(encout_ADD); press(8'd1); press(8'd7);
        n_checks++;
        if ({A1, A0, B1, B0, OP} !== {8'd4, 8'd2, 8'd1, 8'd7, encout_ADD}) begin
            n_errors++;
            $display("FAIL add_operands: got A=%0d%0d B=%0d%0d OP=%0d, required A=42 B=17 OP=%0d",
                     A1, A0, B1, B0, OP, encout_ADD);
        end
        do_eq(42, 17, encout_ADD, "add_42_17");
    endtask

    task automatic test_sub_neg();
        press(8'd3);
        n_checks++;
        if ({A1, A0, result_valid, state} !== {8'd0, 8'd3, 1'b0, ST_ENT_A}) begin
            n_errors++;
            $display("FAIL show_digit: got A=%0d%0d rv=%0b state=%0d, required A=03 rv=0 state=0",
                     A1, A0, result_valid, state);
        end
        press(encout_SUB); press(8'd1); press(8'd2);
        do_eq(3, 12, encout_SUB, "sub_3_12");
    endtask

    task automatic test_mult_max();
        press(8'd9); press(8'd9); press(encout_Mult); press(8'd9); press(8'd9);
        do_eq(99, 99, encout_Mult, "mult_99_99");
    endtask

    task automatic test_div_zero();
        press(8'd5); press(encout_Div); press(8'd0);
        do_eq(5, 0, encout_Div, "div_5_0");
        press(8'd7); press(encout_EQ);
        n_checks++;
        if ({state, err, A0, result_valid} !== {ST_ERR, 1'b1, 8'd5, 1'b0}) begin
            n_errors++;
            $display("FAIL err_hold: got state=%0d err=%0b A0=%0d rv=%0b, required 4/1/5/0",
                     state, err, A0, result_valid);
        end
        press(encout_CLR);
        n_checks++;
        if ({A1, A0, B1, B0, OP, result, neg, err, result_valid, calc_rst, state} !== RESET_VEC) begin
            n_errors++;
            $display("FAIL clr_from_err: got state=%0d err=%0b result=%0d calc_rst=%0b A=%0d%0d",
                     state, err, result, calc_rst, A1, A0);
        end
    endtask

    task automatic test_digit_limits();
        press(8'd1); press(8'd2); press(8'd3);
        n_checks++;
        if ({A1, A0} !== {8'd1, 8'd2}) begin
            n_errors++;
            $display("FAIL third_digit: got A=%0d%0d, required 12", A1, A0);
        end
        press(encout_ADD); press(encout_EQ);
        n_checks++;
        if (state !== ST_ENT_B) begin
            n_errors++;
            $display("FAIL bare_eq: got state=%0d, required %0d", state, ST_ENT_B);
        end
        press(8'd4);
        do_eq(12, 4, encout_ADD, "add_12_4");
        press(8'd6);
        n_checks++;
        if ({A1, A0, B1, B0, OP, result_valid, state} !==
            {8'd0, 8'd6, 8'd0, 8'd0, 8'd0, 1'b0, ST_ENT_A}) begin
            n_errors++;
            $display("FAIL show_restart: got A=%0d%0d B=%0d%0d OP=%0d rv=%0b state=%0d, required A=06 B=00 OP=0 rv=0 state=0",
                     A1, A0, B1, B0, OP, result_valid, state);
        end
    endtask

    task automatic test_rst_in_calc();
        press(encout_CLR);
        press(8'd2); press(encout_ADD); press(8'd3);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = encout_EQ;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = '0;
        n_checks++;
        if ({state, calc_rst} !== {ST_CALC, 1'b0}) begin
            n_errors++;
            $display("FAIL calc_entry: got state=%0d calc_rst=%0b, required 2/0", state, calc_rst);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({A1, A0, B1, B0, OP, result, neg, err, result_valid, calc_rst, state} !== RESET_VEC) begin
            n_errors++;
            $display("FAIL rst_in_calc: got state=%0d rv=%0b result=%0d calc_rst=%0b",
                     state, result_valid, result, calc_rst);
        end
    endtask

    task automatic test_back_to_back();
        logic [W_KEY-1:0] ops[4];
        ops[0] = encout_ADD;
        ops[1] = encout_SUB;
        ops[2] = encout_Mult;
        ops[3] = encout_Div;
        press(encout_CLR);
        for (int k = 0; k < 8; k++) begin
            int a, b, o;
            a = int'($urandom_range(0, 99));
            b = int'($urandom_range(0, 99));
            o = int'($urandom_range(0, 3));
            if (k == 5) b = 0;
            if (err) press(encout_CLR);
            enter_num(a);
            press(ops[o]);
            enter_num(b);
            do_eq(a, b, ops[o], $sformatf("b2b_%0d", k));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add();
        test_sub_neg();
        test_mult_max();
        test_div_zero();
        test_digit_limits();
        test_rst_in_calc();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Keypad-to-arithmetic sequencer for the two-operand decimal calculator. Consumes one-cycle key events from the keypad encoder and assembles up to two decimal digits per operand plus an operator. On "=" it enables the combinational `calculation` block for one cycle, captures its 14-bit output and holds the result, sign and error flags for the display path. Sits between `keypad` and `calculation`; drives every operand/operator input and the `rst` input of `calculation`.

## Interface
Parameters:
- `W_OUT`, 14: result width; matches `calculation.out`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid this cycle.
- `key_code`  in  8  digits 8'd0–8'd9, or one of `encout_ADD`/`encout_SUB`/`encout_Mult`/`encout_Div`/`encout_EQ`/`encout_CLR`.
- `A1`,`A0`,`B1`,`B0`  out  8 each  operand tens/units digits (0–9) to `calculation`.
- `OP`  out  8  latched operator code to `calculation`.
- `calc_rst`  out  1  drives `calculation.rst`; low only in CALC and SHOW.
- `calc_out`  in  14  `calculation.out`.
- `result`  out  14  magnitude of the last result.
- `neg`  out  1  result is negative (SUB with A<B).
- `err`  out  1  divide-by-zero.
- `result_valid`  out  1  `result`/`neg` are valid.
- `state`  out  3  current state, for display mux.

## Operation
- States: ENT_A, ENT_B, CALC, SHOW, ERR. Reset → ENT_A.
- Reset values: `A1`,`A0`,`B1`,`B0`,`OP` = 0; digit counters = 0; `result` = 0; `neg`, `err`, `result_valid` = 0; `calc_rst` = 1.
- Digit entry (ENT_A for A, ENT_B for B): 1st digit → units = d, tens = 0, cnt = 1. 2nd digit → tens = old units, units = d, cnt = 2. Further digits are ignored.
- ENT_A:
  - Operator key with cnt ≥ 1 → latch `OP`, go to ENT_B.
  - Operator key with cnt = 0 is ignored.
  - EQ is ignored.
- ENT_B:
  - EQ with cnt ≥ 1 → CALC.
  - EQ with cnt = 0 is ignored.
  - Operator keys overwrite `OP` while cnt = 0 and are ignored after that.
- CALC (exactly one cycle, `calc_rst` = 0, all keys except CLR ignored):
  - `OP` = Div and B = 0 → ERR, `err` = 1.
  - `OP` = SUB and A < B → `result` = two's-complement negation of `calc_out` (i.e. B−A), `neg` = 1.
  - Otherwise → `result` = `calc_out`, `neg` = 0.
  - Non-error exit sets `result_valid` = 1 and goes to SHOW.
- SHOW: outputs hold. A digit key clears B, `OP`, flags and counters, loads A0 = d, A1 = 0 (A cnt = 1) and goes to ENT_A. Operator and EQ keys are ignored.
- ERR: only CLR exits. All other keys are ignored.
- CLR in any state: same effect as `rst`, one edge later.
- Width rule: A·B ≤ 99·99 = 9801 < 2^14, so no overflow is possible. Division is integer truncation.

## Timing
- A key is sampled on the edge where `key_valid` = 1. Registers and state reflect it after that edge.
- Latency:
  - EQ sampled at edge t → CALC during cycle t..t+1 → `result`/`result_valid` visible after edge t+1.
  - Total EQ-to-result latency is 2 edges.
- `calc_rst` is registered from state, so it falls in the same cycle CALC begins. `calculation` is combinational, so `calc_out` settles within CALC.
- Keys arrive at most one per cycle. A `key_valid` in CALC is dropped, except CLR.
- `rst` has priority over CLR and any key in the same cycle.

## Structure
- Shared defines (keypad header):
  - Existing `encout_ADD`/`encout_SUB`/`encout_Mult`/`encout_Div`.
  - New `encout_EQ`, `encout_CLR`.
  - New state-encoding macros `ST_ENT_A`…`ST_ERR`, so the display block decodes `state` identically.
- One sub-module, `calc_digit_shift`:
  - Two-digit shift register with 2-bit count, clear and load-first-digit inputs.
  - Instantiated twice, for A and B.

## Test plan
- Keys 4,2,ADD,1,7,EQ → A1/A0 = 4/2, B1/B0 = 1/7, `result` = 59, `neg` = 0, `result_valid` high 2 edges after EQ.
- Keys 3,SUB,1,2,EQ → `result` = 9, `neg` = 1.
- Keys 9,9,Mult,9,9,EQ → `result` = 9801.
- Keys 5,Div,0,EQ → `err` = 1, `result_valid` = 0, state ERR. Keys 7 and EQ are ignored there; CLR → ENT_A with all outputs at reset values.
- Keys 1,2,3,ADD,EQ,4,EQ → third digit dropped (A = 12), bare EQ ignored, `result` = 16. Then digit 6 in SHOW → A0 = 6, `result_valid` = 0, state ENT_A.
- `rst` asserted in CALC → next cycle: all outputs at reset values, `calc_rst` = 1.
